// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared definitions for the single-port SRAM controller:
//     - state_t : controller FSM encoding (ST_INIT exists only when the
//                 SRAM_CTRL_INIT_EN macro is defined)
//     - MEM_RD / MEM_WR : values driven on the SRAM direction pin
//   Build option: SRAM_CTRL_INIT_EN adds the post-reset zero-fill state.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package sram_ctrl_pkg;

`ifdef SRAM_CTRL_INIT_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_INIT    = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;
`endif

  // SRAM direction encoding on mem_rw / req_rw.
  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

endpackage : sram_ctrl_pkg

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//   Single-request controller in front of a synchronous single-port SRAM.
//   A request is accepted only in IDLE (req_ready=1). The SRAM is strobed for
//   exactly one cycle (ACCESS). Writes return straight to IDLE; reads wait
//   RD_LAT-1 cycles (WAIT), capture mem_dout (CAPTURE) and present the data
//   with a one-cycle rsp_valid strobe that coincides with the return to IDLE.
//
//   Build option: define SRAM_CTRL_INIT_EN to add an INIT state that, after
//   every reset, writes zero to all 2^ADDR_W locations before going IDLE.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data width
//   RD_LAT  SRAM read latency after the sampling edge, legal 1..4
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  client request valid
//   req_ready  controller can accept a request (IDLE only)
//   req_rw     1 = write, 0 = read
//   req_addr   request address
//   req_wdata  request write data
//   rsp_valid  one-cycle read-data strobe
//   rsp_rdata  read data, held until the next capture
//   busy       controller is not IDLE
//   mem_en     SRAM strobe
//   mem_rw     SRAM direction
//   mem_addr   SRAM address (0 whenever mem_en=0)
//   mem_din    SRAM write data (0 whenever mem_en=0)
//   mem_dout   SRAM read data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  // Wait counter sized to hold RD_LAT; it is loaded with the number of WAIT
  // cycles (RD_LAT-1) while in ACCESS.
  localparam int               CNT_W     = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef SRAM_CTRL_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t              r_state;
  state_t              w_next;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                w_handshake;
  logic                w_mem_en;
  logic                w_mem_rw;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_din;

  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign w_handshake = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture: the client bus is a don't-care once accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw    <= MEM_RD;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_handshake) begin
      r_rw    <= req_rw;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-latency down-counter, reloaded on every ACCESS.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_wait_cnt <= WAIT_LOAD;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt - CNT_ONE;
    end
  end

`ifdef SRAM_CTRL_INIT_EN
  // ---------------------------------------------------------------------------
  // Zero-fill address walker; restarts at 0 on every reset.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_init_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_addr <= r_init_addr + ADDR_W'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state and SRAM-side outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path through
  // the case leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next     = r_state;
    w_mem_en   = 1'b0;
    w_mem_rw   = MEM_RD;
    w_mem_addr = '0;
    w_mem_din  = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        w_mem_en   = 1'b1;
        w_mem_rw   = r_rw;
        w_mem_addr = r_addr;
        w_mem_din  = r_wdata;
        if (r_rw == MEM_WR) begin
          w_next = ST_IDLE;
        end else if (RD_LAT == 1) begin
          w_next = ST_CAPTURE;
        end else begin
          w_next = ST_WAIT;
        end
      end

      // Counter holds the remaining WAIT cycles including this one.
      ST_WAIT: begin
        if (r_wait_cnt == CNT_ONE) begin
          w_next = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        w_next = ST_IDLE;
      end

`ifdef SRAM_CTRL_INIT_EN
      ST_INIT: begin
        w_mem_en   = 1'b1;
        w_mem_rw   = MEM_WR;
        w_mem_addr = r_init_addr;
        if (&r_init_addr) begin
          w_next = ST_IDLE;
        end
      end
`endif

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // While reset is held the SRAM must see no strobe, even though the reset
  // state may be INIT (which strobes once running).
  assign mem_en   = w_mem_en & ~rst;
  assign mem_rw   = w_mem_rw & ~rst;
  assign mem_addr = rst ? '0 : w_mem_addr;
  assign mem_din  = rst ? '0 : w_mem_din;

  // ---------------------------------------------------------------------------
  // Read response: CAPTURE samples the SRAM, so the strobe lands in the cycle
  // the FSM is back in IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= (r_state == ST_CAPTURE);
      if (r_state == ST_CAPTURE) begin
        r_rsp_rdata <= mem_dout;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule : sram_ctrl

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//   Directed bench for sram_ctrl. Two controllers share one request bus:
//   u_dut1 (RD_LAT=1) and u_dut3 (RD_LAT=3), each with its own SRAM model.
//   With SRAM_CTRL_INIT_EN defined a third instance u_dut4 (ADDR_W=4,
//   RD_LAT=1, SRAM preloaded with 0xFF) exercises the zero-fill sequence.
//   The SRAM models return 0xEE whenever no read result is due, so a capture
//   on the wrong cycle shows up as wrong data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

`ifdef SRAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       preload = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rw = MEM_RD;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT 1
  logic       req_ready_1, rsp_valid_1, busy_1, mem_en_1, mem_rw_1;
  logic [7:0] rsp_rdata_1, mem_addr_1, mem_din_1, mem_dout_1;
  logic [7:0] m1 [256];
  logic [7:0] p1;

  sram_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_1),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1), .busy(busy_1),
    .mem_en(mem_en_1), .mem_rw(mem_rw_1), .mem_addr(mem_addr_1),
    .mem_din(mem_din_1), .mem_dout(mem_dout_1)
  );

  always @(posedge clk) begin
    p1 <= 8'hEE;
    if (preload) begin
      for (int i = 0; i < 256; i++) m1[i] <= 8'h00;
    end else if (mem_en_1 && mem_rw_1) begin
      m1[mem_addr_1] <= mem_din_1;
    end else if (mem_en_1) begin
      p1 <= m1[mem_addr_1];
    end
  end
  assign mem_dout_1 = p1;

  // ---------------------------------------------------------------- DUT 3
  logic       req_ready_3, rsp_valid_3, busy_3, mem_en_3, mem_rw_3;
  logic [7:0] rsp_rdata_3, mem_addr_3, mem_din_3, mem_dout_3;
  logic [7:0] m3 [256];
  logic [7:0] p3a, p3b, p3c;

  sram_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_3),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_3), .rsp_rdata(rsp_rdata_3), .busy(busy_3),
    .mem_en(mem_en_3), .mem_rw(mem_rw_3), .mem_addr(mem_addr_3),
    .mem_din(mem_din_3), .mem_dout(mem_dout_3)
  );

  always @(posedge clk) begin
    p3a <= 8'hEE;
    p3b <= p3a;
    p3c <= p3b;
    if (preload) begin
      for (int i = 0; i < 256; i++) m3[i] <= 8'h00;
    end else if (mem_en_3 && mem_rw_3) begin
      m3[mem_addr_3] <= mem_din_3;
    end else if (mem_en_3) begin
      p3a <= m3[mem_addr_3];
    end
  end
  assign mem_dout_3 = p3c;

`ifdef SRAM_CTRL_INIT_EN
  // ---------------------------------------------------------------- DUT 4
  logic       req_ready_4, rsp_valid_4, busy_4, mem_en_4, mem_rw_4;
  logic [7:0] rsp_rdata_4, mem_din_4, mem_dout_4;
  logic [3:0] mem_addr_4;
  logic [7:0] m4 [16];
  logic [7:0] p4;

  sram_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_4),
    .req_rw(req_rw), .req_addr(req_addr[3:0]), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_4), .rsp_rdata(rsp_rdata_4), .busy(busy_4),
    .mem_en(mem_en_4), .mem_rw(mem_rw_4), .mem_addr(mem_addr_4),
    .mem_din(mem_din_4), .mem_dout(mem_dout_4)
  );

  always @(posedge clk) begin
    p4 <= 8'hEE;
    if (preload) begin
      for (int i = 0; i < 16; i++) m4[i] <= 8'hFF;
    end else if (mem_en_4 && mem_rw_4) begin
      m4[mem_addr_4] <= mem_din_4;
    end else if (mem_en_4) begin
      p4 <= m4[mem_addr_4];
    end
  end
  assign mem_dout_4 = p4;

  logic all_ready;
  assign all_ready = req_ready_1 & req_ready_3 & req_ready_4;
`else
  logic all_ready;
  assign all_ready = req_ready_1 & req_ready_3;
`endif

  // ------------------------------------------------------------- helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!all_ready && n < 400) begin
      step();
      n++;
    end
    n_tests++;
    if (all_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_idle: req_ready=%b, required 1 within 400 cycles", tag, all_ready);
    end
  endtask

  // Issue a read on the shared bus and return dut1's response two cycles
  // after the handshake edge.
  task automatic do_read1(input logic [7:0] a, output logic v, output logic [7:0] d);
    req_valid = 1'b1; req_rw = MEM_RD; req_addr = a;
    step();
    req_valid = 1'b0;
    step();
    step();
    v = rsp_valid_1;
    d = rsp_rdata_1;
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    step();
    step();
    preload = 1'b0;
    n_tests++;
    if (busy_1 !== INIT_EN) begin
      n_fail++; $display("FAIL rst_busy: got %b, required %b", busy_1, INIT_EN);
    end
    n_tests++;
    if ({mem_en_1, mem_rw_1, mem_addr_1, mem_din_1} !== 18'h0) begin
      n_fail++; $display("FAIL rst_mem: got en=%b rw=%b addr=%h din=%h, required all 0",
                         mem_en_1, mem_rw_1, mem_addr_1, mem_din_1);
    end
    n_tests++;
    if ({rsp_valid_1, rsp_rdata_1} !== 9'h0) begin
      n_fail++; $display("FAIL rst_rsp: got valid=%b rdata=%h, required 0/00", rsp_valid_1, rsp_rdata_1);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (req_ready_3 !== !INIT_EN) begin
      n_fail++; $display("FAIL rst_ready: got %b, required %b", req_ready_3, !INIT_EN);
    end
  endtask

`ifdef SRAM_CTRL_INIT_EN
  task automatic test_init();
    logic       v;
    logic [7:0] d;
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if ({busy_4, req_ready_4, mem_en_4, mem_rw_4, mem_addr_4, mem_din_4} !==
          {1'b1, 1'b0, 1'b1, 1'b1, 4'(k), 8'h00}) begin
        n_fail++; $display("FAIL init_%0d: got busy=%b rdy=%b en=%b rw=%b addr=%h din=%h, required 1 0 1 1 %h 00",
                           k, busy_4, req_ready_4, mem_en_4, mem_rw_4, mem_addr_4, mem_din_4, 4'(k));
      end
      step();
    end
    n_tests++;
    if ({busy_4, req_ready_4, mem_en_4} !== 3'b010) begin
      n_fail++; $display("FAIL init_done: got busy=%b rdy=%b en=%b, required 0 1 0", busy_4, req_ready_4, mem_en_4);
    end
    wait_idle("init");
    req_valid = 1'b1; req_rw = MEM_RD; req_addr = 8'h09;
    step();
    req_valid = 1'b0;
    step();
    step();
    v = rsp_valid_4;
    d = rsp_rdata_4;
    n_tests++;
    if ({v, d} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL init_read9: got valid=%b rdata=%h, required 1/00", v, d);
    end
    wait_idle("init_read");
  endtask
`endif

  task automatic test_write_read();
    wait_idle("wr");
    req_valid = 1'b1; req_rw = MEM_WR; req_addr = 8'h12; req_wdata = 8'hA5;
    step();
    req_valid = 1'b0; req_addr = 8'h55; req_wdata = 8'h66;
    n_tests++;
    if ({mem_en_1, mem_rw_1, mem_addr_1, mem_din_1, req_ready_1, busy_1} !== {1'b1, 1'b1, 8'h12, 8'hA5, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL wr_access: got en=%b rw=%b addr=%h din=%h rdy=%b busy=%b, required 1 1 12 a5 0 1",
                         mem_en_1, mem_rw_1, mem_addr_1, mem_din_1, req_ready_1, busy_1);
    end
    step();
    n_tests++;
    if ({mem_en_1, mem_addr_1, mem_din_1, req_ready_1, rsp_valid_1} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL wr_done: got en=%b addr=%h din=%h rdy=%b rsp=%b, required 0 00 00 1 0",
                         mem_en_1, mem_addr_1, mem_din_1, req_ready_1, rsp_valid_1);
    end
    req_valid = 1'b1; req_rw = MEM_RD; req_addr = 8'h12;
    step();
    req_valid = 1'b0; req_addr = 8'h00;
    n_tests++;
    if ({mem_en_1, mem_rw_1, mem_addr_1, req_ready_1} !== {1'b1, 1'b0, 8'h12, 1'b0}) begin
      n_fail++; $display("FAIL rd_access: got en=%b rw=%b addr=%h rdy=%b, required 1 0 12 0",
                         mem_en_1, mem_rw_1, mem_addr_1, req_ready_1);
    end
    step();
    n_tests++;
    if ({mem_en_1, rsp_valid_1, busy_1} !== 3'b001) begin
      n_fail++; $display("FAIL rd_capture: got en=%b rsp=%b busy=%b, required 0 0 1", mem_en_1, rsp_valid_1, busy_1);
    end
    step();
    n_tests++;
    if ({rsp_valid_1, rsp_rdata_1, req_ready_1} !== {1'b1, 8'hA5, 1'b1}) begin
      n_fail++; $display("FAIL rd_rsp: got valid=%b rdata=%h rdy=%b, required 1 a5 1", rsp_valid_1, rsp_rdata_1, req_ready_1);
    end
    step();
    n_tests++;
    if ({rsp_valid_1, rsp_rdata_1} !== {1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL rd_hold: got valid=%b rdata=%h, required 0 a5", rsp_valid_1, rsp_rdata_1);
    end
  endtask

  task automatic test_read_lat3();
    wait_idle("lat3");
    req_valid = 1'b1; req_rw = MEM_WR; req_addr = 8'h7F; req_wdata = 8'h3C;
    step();
    req_valid = 1'b0;
    step();
    req_valid = 1'b1; req_rw = MEM_RD; req_addr = 8'h7F;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_tests++;
      if ({rsp_valid_3, req_ready_3} !== {(k == 4), (k == 4)}) begin
        n_fail++; $display("FAIL lat3_cyc%0d: got rsp=%b rdy=%b, required %b %b",
                           k, rsp_valid_3, req_ready_3, (k == 4), (k == 4));
      end
    end
    n_tests++;
    if (rsp_rdata_3 !== 8'h3C) begin
      n_fail++; $display("FAIL lat3_data: got %h, required 3c", rsp_rdata_3);
    end
    step();
    n_tests++;
    if (rsp_valid_3 !== 1'b0) begin
      n_fail++; $display("FAIL lat3_pulse: rsp_valid got %b, required 0", rsp_valid_3);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] got, exp;
    logic [7:0]  a, w, d;
    logic        v;
    wait_idle("b2b");
    req_valid = 1'b1; req_rw = MEM_WR;
    for (int k = 0; k < 8; k++) begin
      a = 8'h20 + 8'(k);
      w = 8'h40 + 8'(k);
      req_addr = a; req_wdata = w;
      step();
      got = {mem_en_1, mem_rw_1, mem_addr_1, mem_din_1, req_ready_1};
      exp = (k % 2 == 0) ? {1'b1, 1'b1, a, w, 1'b0} : 19'h00001;
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL b2b_cyc%0d: got {en,rw,addr,din,rdy}=%h, required %h", k, got, exp);
      end
    end
    req_valid = 1'b0;
    wait_idle("b2b_end");
    do_read1(8'h26, v, d);
    n_tests++;
    if ({v, d} !== {1'b1, 8'h46}) begin
      n_fail++; $display("FAIL b2b_rd26: got valid=%b rdata=%h, required 1 46", v, d);
    end
    wait_idle("b2b_rd26");
    do_read1(8'h21, v, d);
    n_tests++;
    if ({v, d} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL b2b_rd21: got valid=%b rdata=%h, required 1 00 (not taken)", v, d);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    wait_idle("rmid");
    req_valid = 1'b1; req_rw = MEM_RD; req_addr = 8'h12;
    step();
    req_valid = 1'b0;
    step();
    n_tests++;
    if ({busy_3, mem_en_3} !== 2'b10) begin
      n_fail++; $display("FAIL rmid_wait: got busy=%b en=%b, required 1 0", busy_3, mem_en_3);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy_3, mem_en_3, rsp_valid_3, req_ready_3} !== {INIT_EN, 1'b0, 1'b0, !INIT_EN}) begin
      n_fail++; $display("FAIL rmid_async: got busy=%b en=%b rsp=%b rdy=%b, required %b 0 0 %b",
                         busy_3, mem_en_3, rsp_valid_3, req_ready_3, INIT_EN, !INIT_EN);
    end
    step();
    n_tests++;
    if ({rsp_valid_1, rsp_rdata_1, rsp_valid_3} !== 10'h0) begin
      n_fail++; $display("FAIL rmid_abandon: got rsp1=%b rdata1=%h rsp3=%b, required 0 00 0",
                         rsp_valid_1, rsp_rdata_1, rsp_valid_3);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rsp_valid_3 === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL rmid_norsp: got %0d rsp_valid pulses, required 0", pulses);
    end
    wait_idle("rmid_post");
    req_valid = 1'b1; req_rw = MEM_WR; req_addr = 8'h33; req_wdata = 8'h5A;
    step();
    req_valid = 1'b0;
    step();
    req_valid = 1'b1; req_rw = MEM_RD;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    n_tests++;
    if ({rsp_valid_3, rsp_rdata_3} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL rmid_read: got valid=%b rdata=%h, required 1 5a", rsp_valid_3, rsp_rdata_3);
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
`ifdef SRAM_CTRL_INIT_EN
    test_init();
`endif
    test_write_read();
    test_read_lat3();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 ns");
    $fatal(1);
  end

endmodule : tb_sram_ctrl
